clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Parametrised, fully synchronous clock-enable/divided-clock generator; the soft successor to the fixed five-output vendor PLL wrapper.
- Produces NUM_CH independently programmable divided outputs from refclk, each with a phase offset and an enable pulse.
- Lock-qualified like a PLL: asserts extlock only after a settle interval. Reconfiguration forces a relock so all channels restart phase-aligned.
- Sits beside the PLL and feeds slow peripheral domains (game tick, VGA pixel enable, audio) as clock enables on refclk.

Parameters:
- NUM_CH, 5, number of output channels (1..16).
- DIV_W, 8, divisor and phase register width.
- DEF_DIV, 2, divisor loaded into every channel at reset (must be < 2^DIV_W).
- LOCK_CYCLES, 16, settle cycles before extlock asserts (>=1).

Ports:
- refclk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  4  channel index for the write.
- cfg_div  in  DIV_W  divisor N; 0 disables the channel.
- cfg_phase  in  DIV_W  initial counter value after lock.
- ch_en  in  NUM_CH  per-channel run mask.
- clk_out  out  NUM_CH  divided square outputs (registered).
- clk_en  out  NUM_CH  one-cycle pulse per period (registered).
- extlock  out  1  outputs valid and aligned.

Behaviour:
- Reset (synchronous, active-high): div_i=DEF_DIV, phase_i=0, cnt_i=0, clk_out=0, clk_en=0, extlock=0, lock_cnt=0, FSM=LOCKING. Reset mid-operation discards all cfg writes.
- FSM, two states:
  - LOCKING: lock_cnt increments each cycle; all outputs held 0, counters held. When lock_cnt==LOCK_CYCLES-1 -> RUN; at that edge each cnt_i loads ph_i and extlock goes 1.
  - ph_i = phase_i if phase_i < div_i, else 0.
  - Timing: with reset low from edge k, extlock=1 after edge k+LOCK_CYCLES.
  - RUN: counters run and extlock stays 1.
- Config write with cfg_we=1 and cfg_ch<NUM_CH:
  - div/phase registers for that channel update at the edge.
  - FSM -> LOCKING with lock_cnt=0; extlock, clk_out and clk_en are 0 from the next cycle.
  - A write during LOCKING restarts lock_cnt.
- cfg_ch>=NUM_CH: write ignored, no relock.
- Counter in RUN, with N=div_i:
  - cnt_i wraps 0..N-1 (next = cnt==N-1 ? 0 : cnt+1).
  - Outputs reflect the current cnt_i value; they are registered from the next-count logic, so there is no extra latency.
- clk_en_i=1 when cnt_i==N-1. N=1: high every cycle.
- clk_out_i=1 when cnt_i < ceil(N/2) (computed as (N+1)>>1 in DIV_W+1 bits, no overflow).
  - N=1: constant 1.
  - N=2: 50% duty.
  - N=3: high 2 cycles, low 1.
- N=0: clk_out_i=0, clk_en_i=0, cnt_i held 0.
- ch_en_i=0 in RUN:
  - cnt_i holds ph_i; clk_out_i and clk_en_i are forced 0.
  - On re-enable, counting resumes from ph_i. This is not realigned to other channels; only a relock realigns.
- Channels are independent of each other. A simultaneous relock and terminal count: relock wins, and no clk_en pulse is emitted.

Test Plan:
- Reset 3 cycles, then release; defaults, LOCK_CYCLES=16 -> extlock rises exactly 16 cycles after release. All clk_out toggle 1,0,1,0… in phase; clk_en high on every odd cycle after lock.
- Write ch0 div=5 phase=0, ch1 div=5 phase=2 -> extlock drops the next cycle and returns after 16 cycles.
  - ch0 clk_out: 1,1,1,0,0 repeating; clk_en every 5th cycle.
  - ch1 leads ch0 by 2 cycles.
- Write ch2 div=0 -> after relock, ch2 clk_out/clk_en constant 0. Write div=1 -> clk_out constant 1, clk_en constant 1.
- Write ch3 div=4 phase=9 (phase>=div) -> ch3 starts at cnt 0, identical to phase=0. Write cfg_ch=15 with NUM_CH=5 -> no relock; extlock stays 1.
- Second cfg_we issued 8 cycles into LOCKING -> extlock asserts 16 cycles after the second write, not the first.
- In RUN drop ch_en[4] for 7 cycles, then restore -> ch4 outputs 0 during the gap, then resume from ph_4. Assert reset mid-RUN -> next cycle all outputs 0 and divisors back to DEF_DIV.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers on refclk with PLL-style lock qualification.
// Any accepted config write forces a relock so every channel restarts phase-aligned.
module clk_div_bank #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEF_DIV     = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic              extlock
);

  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [0:0] StLocking = 1'b0;
  localparam logic [0:0] StRun     = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic             extlock_d;
  logic             cfg_hit;
  logic             lock_done;

  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] phase_q [NUM_CH];
  logic [DIV_W-1:0] phase_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [DIV_W-1:0] ph      [NUM_CH];
  logic [DIV_W:0]   half    [NUM_CH];

  // act_q marks a channel that counted last cycle; a fresh start loads ph instead of advancing.
  logic [NUM_CH-1:0] act_q, act_d;
  logic [NUM_CH-1:0] clk_out_d, clk_en_d;

  assign cfg_hit   = cfg_we && ({1'b0, cfg_ch} < 5'(NUM_CH));
  assign lock_done = (state_q == StLocking) && (lock_cnt_q == LockW'(LOCK_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (cfg_hit) begin
      state_d    = StLocking;
      lock_cnt_d = '0;
    end else if (state_q == StLocking) begin
      if (lock_done) begin
        state_d    = StRun;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + LockW'(1);
      end
    end
    extlock_d = (state_d == StRun);
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      if (cfg_hit && (cfg_ch == 4'(i))) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
      end
      ph[i]   = (phase_q[i] < div_q[i]) ? phase_q[i] : '0;
      half[i] = ({1'b0, div_q[i]} + (DIV_W + 1)'(1)) >> 1;
    end
  end

  // Outputs are registered from cnt_d so they track the count with no added latency.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      act_d[i]     = 1'b0;
      clk_out_d[i] = 1'b0;
      clk_en_d[i]  = 1'b0;
      if (state_d == StRun) begin
        if (!ch_en[i]) begin
          cnt_d[i] = ph[i];
        end else begin
          act_d[i] = 1'b1;
          if (div_q[i] == '0) begin
            cnt_d[i] = '0;
          end else if (!act_q[i]) begin
            cnt_d[i] = ph[i];
          end else if (cnt_q[i] == div_q[i] - DIV_W'(1)) begin
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
          end
          if (div_q[i] != '0) begin
            clk_out_d[i] = ({1'b0, cnt_d[i]} < half[i]);
            clk_en_d[i]  = (cnt_d[i] == div_q[i] - DIV_W'(1));
          end
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q    <= StLocking;
      lock_cnt_q <= '0;
      extlock    <= 1'b0;
      clk_out    <= '0;
      clk_en     <= '0;
      act_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(DEF_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      extlock    <= extlock_d;
      clk_out    <= clk_out_d;
      clk_en     <= clk_en_d;
      act_q      <= act_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with default parameters (5 channels, 16-cycle lock).
module tb_clk_div_bank;

  logic       refclk;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic [4:0] ch_en;
  logic [4:0] clk_out;
  logic [4:0] clk_en;
  logic       extlock;

  int checks = 0;
  int passes = 0;

  clk_div_bank dut (
    .refclk   (refclk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .ch_en    (ch_en),
    .clk_out  (clk_out),
    .clk_en   (clk_en),
    .extlock  (extlock)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compares {extlock, clk_en, clk_out} in one go.
  task automatic chk_all(input string tag, input logic lk, input logic [4:0] en,
                         input logic [4:0] out);
    chk(tag, {21'b0, extlock, clk_en, clk_out}, {21'b0, lk, en, out});
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [7:0] dv, input logic [7:0] phs);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_phase = phs;
    tick();
    cfg_we    = 1'b0;
  endtask

  // 15 edges still locking, then the 16th edge brings extlock up.
  task automatic wait_lock(input string tag);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk(tag, {31'b0, extlock}, 32'd0);
    end
    tick();
  endtask

  logic [4:0] exp_out_a [6];
  logic [4:0] exp_en_a  [6];
  logic [4:0] exp_out_b [5];
  logic [4:0] exp_en_b  [5];

  initial begin
    exp_out_a = '{5'h1F, 5'h01, 5'h1D, 5'h02, 5'h1E, 5'h03};
    exp_en_a  = '{5'h00, 5'h1C, 5'h02, 5'h1C, 5'h01, 5'h1C};
    exp_out_b = '{5'h1B, 5'h09, 5'h11, 5'h02, 5'h1A};
    exp_en_b  = '{5'h00, 5'h10, 5'h02, 5'h18, 5'h01};

    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0; ch_en = 5'h1F;
    repeat (3) tick();
    chk_all("reset_state", 1'b0, 5'h00, 5'h00);

    reset = 1'b0;
    wait_lock("first_lock_pending");
    chk_all("first_lock", 1'b1, 5'h00, 5'h1F);
    tick();
    chk_all("div2_odd", 1'b1, 5'h1F, 5'h00);
    tick();
    chk_all("div2_even", 1'b1, 5'h00, 5'h1F);

    // ch0 div5 ph0, ch1 div5 ph2 (second write restarts the lock count)
    cfg_write(4'd0, 8'd5, 8'd0);
    chk_all("relock_drop", 1'b0, 5'h00, 5'h00);
    cfg_write(4'd1, 8'd5, 8'd2);
    wait_lock("relock1_pending");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk_all($sformatf("div5_phase_c%0d", i), 1'b1, exp_en_a[i], exp_out_a[i]);
    end

    // ch2 div0, then ch3 div4 phase9 issued 8 cycles into LOCKING
    cfg_write(4'd2, 8'd0, 8'd0);
    chk_all("relock2_drop", 1'b0, 5'h00, 5'h00);
    repeat (7) tick();
    cfg_write(4'd3, 8'd4, 8'd9);
    wait_lock("second_write_restart");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk_all($sformatf("div0_ph_over_c%0d", i), 1'b1, exp_en_b[i], exp_out_b[i]);
    end

    cfg_write(4'd15, 8'd7, 8'd0);
    chk_all("bad_ch_no_relock", 1'b1, 5'h10, 5'h0B);

    // ch2 div1
    cfg_write(4'd2, 8'd1, 8'd0);
    wait_lock("relock3_pending");
    chk_all("div1_c0", 1'b1, 5'h04, 5'h1F);
    tick();
    chk_all("div1_c1", 1'b1, 5'h14, 5'h0D);
    tick();
    chk_all("div1_c2", 1'b1, 5'h06, 5'h15);

    ch_en = 5'h0F;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("ch4_gap_%0d", i), {30'b0, clk_out[4], clk_en[4]}, 32'd0);
    end
    ch_en = 5'h1F;
    tick();
    chk("ch4_resume0", {30'b0, clk_out[4], clk_en[4]}, 32'd2);
    tick();
    chk("ch4_resume1", {30'b0, clk_out[4], clk_en[4]}, 32'd1);
    tick();
    chk("ch4_resume2", {30'b0, clk_out[4], clk_en[4]}, 32'd2);

    // reset mid-run with a concurrent write that must be discarded
    reset = 1'b1;
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd7; cfg_phase = 8'd3;
    tick();
    chk_all("reset_midrun", 1'b0, 5'h00, 5'h00);
    reset = 1'b0;
    cfg_we = 1'b0;
    wait_lock("post_reset_pending");
    chk_all("post_reset_default0", 1'b1, 5'h00, 5'h1F);
    tick();
    chk_all("post_reset_default1", 1'b1, 5'h1F, 5'h00);
    tick();
    chk_all("post_reset_default2", 1'b1, 5'h00, 5'h1F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
